// File: rtl/inst_encoder_loader.sv
// Program loader: packs opcode/field bundles into 16-bit instruction words
// and writes them to sequential instruction-memory addresses from a base.
module inst_encoder_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic              i_in_last,
  input  logic [3:0]        i_in_op,
  input  logic [2:0]        i_in_fa,
  input  logic [2:0]        i_in_fb,
  input  logic [2:0]        i_in_fc,
  input  logic [2:0]        i_in_mode,
  output logic              o_im_we,
  output logic [ADDR_W-1:0] o_im_addr,
  output logic [15:0]       o_im_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err_op,
  output logic              o_full,
  output logic [ADDR_W:0]   o_word_count
);

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8;
  localparam logic [3:0] OP_JMP = 4'd9;
  localparam logic [3:0] OP_JZ  = 4'd10;
  localparam logic [3:0] OP_LW  = 4'd11;
  localparam logic [3:0] OP_SW  = 4'd12;
  localparam logic [3:0] OP_MV  = 4'd13;

  localparam logic [ADDR_W-1:0] ONE_ADDR = 1;
  localparam logic [ADDR_W:0]   ONE_CNT  = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [ADDR_W-1:0]   r_waddr;
  logic [15:0]         r_wdata;
  logic [ADDR_W:0]     r_count;
  logic                r_err;
  logic                r_full;

  logic                w_accept;
  logic                w_known;
  logic                w_at_top;
  logic [15:0]         w_word;

  assign w_accept = (r_state == S_LOAD) && i_in_valid;
  assign w_at_top = (r_addr == {ADDR_W{1'b1}});

  // Unused fields are forced to zero so the decoder never sees stale bits.
  always_comb begin
    w_known = 1'b1;
    w_word  = 16'h0000;
    case (i_in_op)
      OP_NOP: w_word = {i_in_op, 12'b0};
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT,
      OP_SLL, OP_SRL, OP_JMP, OP_JZ:
              w_word = {i_in_op, i_in_fa, i_in_fb, i_in_fc, i_in_mode};
      OP_SW:  w_word = {i_in_op, 6'b0, i_in_fc, 3'b0};
      OP_LW, OP_MV:
              w_word = {i_in_op, i_in_fa, 9'b0};
      default: w_known = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_next = S_LOAD;
      S_LOAD: if (w_accept && (i_in_last || (w_known && w_at_top))) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      r_full  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_we    <= 1'b0;
      if (r_state == S_IDLE && i_start) begin
        r_addr  <= i_base_addr;
        r_count <= '0;
        r_err   <= 1'b0;
        r_full  <= 1'b0;
      end
      if (w_accept) begin
        if (w_known) begin
          r_we    <= 1'b1;
          r_waddr <= r_addr;
          r_wdata <= w_word;
          r_count <= r_count + ONE_CNT;
          // Saturate at the top address; the session ends here, so no wrap.
          if (w_at_top) r_full <= 1'b1;
          else          r_addr <= r_addr + ONE_ADDR;
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign o_in_ready   = (r_state == S_LOAD);
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = (r_state == S_DONE);
  assign o_im_we      = r_we;
  assign o_im_addr    = r_waddr;
  assign o_im_wdata   = r_wdata;
  assign o_err_op     = r_err;
  assign o_full       = r_full;
  assign o_word_count = r_count;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed bench for inst_encoder_loader: packing table plus hand-written
// multi-cycle sessions (back-to-back, unknown op, full, reset, start ignore).
module tb_inst_encoder_loader;

  localparam int ADDR_W = 8;

  localparam logic [3:0] OP_NOP = 4'd0,  OP_ADD = 4'd1,  OP_XOR = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd7,  OP_JZ  = 4'd10, OP_LW  = 4'd11;
  localparam logic [3:0] OP_SW  = 4'd12, OP_MV  = 4'd13;
  localparam logic [2:0] T0 = 3'd1, T1 = 3'd2, T2 = 3'd3, T3 = 3'd4;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_start;
  logic [ADDR_W-1:0] i_base_addr;
  logic              i_in_valid;
  logic              o_in_ready;
  logic              i_in_last;
  logic [3:0]        i_in_op;
  logic [2:0]        i_in_fa, i_in_fb, i_in_fc, i_in_mode;
  logic              o_im_we;
  logic [ADDR_W-1:0] o_im_addr;
  logic [15:0]       o_im_wdata;
  logic              o_busy, o_done, o_err_op, o_full;
  logic [ADDR_W:0]   o_word_count;

  int total = 0;
  int bad   = 0;

  inst_encoder_loader #(.ADDR_W(ADDR_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_last(i_in_last),
    .i_in_op(i_in_op), .i_in_fa(i_in_fa), .i_in_fb(i_in_fb), .i_in_fc(i_in_fc),
    .i_in_mode(i_in_mode), .o_im_we(o_im_we), .o_im_addr(o_im_addr),
    .o_im_wdata(o_im_wdata), .o_busy(o_busy), .o_done(o_done),
    .o_err_op(o_err_op), .o_full(o_full), .o_word_count(o_word_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  fa, fb, fc, mode;
    logic        we;
    logic [15:0] word;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic begin_session(input logic [ADDR_W-1:0] base);
    i_start     = 1'b1;
    i_base_addr = base;
    tick();
    i_start     = 1'b0;
  endtask

  task automatic drive(input logic [3:0] op, input logic [2:0] fa, input logic [2:0] fb,
                       input logic [2:0] fc, input logic [2:0] mode, input logic last);
    i_in_valid = 1'b1;
    i_in_op    = op;
    i_in_fa    = fa;
    i_in_fb    = fb;
    i_in_fc    = fc;
    i_in_mode  = mode;
    i_in_last  = last;
  endtask

  task automatic idle_in();
    i_in_valid = 1'b0;
    i_in_last  = 1'b0;
  endtask

  task automatic check_write(input string name, input logic [ADDR_W-1:0] addr,
                             input logic [15:0] word);
    check({name, ".we"}, 32'(o_im_we), 32'd1);
    check({name, ".addr"}, 32'(o_im_addr), 32'(addr));
    check({name, ".data"}, 32'(o_im_wdata), 32'(word));
  endtask

  initial begin
    vecs[0] = '{OP_ADD, T0, T1, T2, 3'd0, 1'b1, 16'h1298};
    vecs[1] = '{OP_SW,  3'd7, 3'd7, T3, 3'd5, 1'b1, 16'hC020};
    vecs[2] = '{OP_LW,  3'd5, 3'd3, 3'd2, 3'd6, 1'b1, 16'hBA00};
    vecs[3] = '{OP_MV,  3'd2, 3'd1, 3'd1, 3'd1, 1'b1, 16'hD400};
    vecs[4] = '{OP_NOP, 3'd7, 3'd7, 3'd7, 3'd7, 1'b1, 16'h0000};
    vecs[5] = '{OP_SLL, 3'd7, 3'd0, 3'd5, 3'd2, 1'b1, 16'h7E2A};
    vecs[6] = '{OP_JZ,  3'd0, 3'd6, 3'd1, 3'd3, 1'b1, 16'hA18B};
    vecs[7] = '{OP_XOR, 3'd4, 3'd4, 3'd4, 3'd4, 1'b1, 16'h5924};
    vecs[8] = '{4'd14,  3'd1, 3'd2, 3'd3, 3'd4, 1'b0, 16'h0000};
    vecs[9] = '{4'd15,  3'd7, 3'd7, 3'd7, 3'd7, 1'b0, 16'h0000};

    i_rst = 1'b1; i_start = 1'b0; i_base_addr = '0;
    i_in_valid = 1'b0; i_in_last = 1'b0; i_in_op = '0;
    i_in_fa = '0; i_in_fb = '0; i_in_fc = '0; i_in_mode = '0;
    tick(); tick();
    check("rst.we", 32'(o_im_we), 32'd0);
    check("rst.flags", 32'({o_busy, o_done, o_err_op, o_full, o_in_ready}), 32'd0);
    check("rst.count", 32'(o_word_count), 32'd0);
    i_rst = 1'b0;
    tick();
    check("idle.busy", 32'(o_busy), 32'd0);

    // Packing table: each vector is a one-bundle session ending with in_last.
    for (int v = 0; v < 10; v++) begin
      begin_session(8'h40);
      check($sformatf("v%0d.ready", v), 32'(o_in_ready), 32'd1);
      drive(vecs[v].op, vecs[v].fa, vecs[v].fb, vecs[v].fc, vecs[v].mode, 1'b1);
      tick();
      idle_in();
      check($sformatf("v%0d.we", v), 32'(o_im_we), 32'(vecs[v].we));
      if (vecs[v].we) begin
        check($sformatf("v%0d.data", v), 32'(o_im_wdata), 32'(vecs[v].word));
        check($sformatf("v%0d.addr", v), 32'(o_im_addr), 32'h40);
      end
      check($sformatf("v%0d.done", v), 32'(o_done), 32'd1);
      check($sformatf("v%0d.err", v), 32'(o_err_op), 32'(!vecs[v].we));
      check($sformatf("v%0d.count", v), 32'(o_word_count), 32'(vecs[v].we));
      tick();
    end

    // Back-to-back adds, last on the third.
    begin_session(8'h10);
    drive(OP_ADD, T0, T1, T2, 3'd0, 1'b0);
    tick();
    check_write("b2b.0", 8'h10, 16'h1298);
    check("b2b.0.done", 32'(o_done), 32'd0);
    tick();
    check_write("b2b.1", 8'h11, 16'h1298);
    drive(OP_ADD, T0, T1, T2, 3'd0, 1'b1);
    tick();
    idle_in();
    check_write("b2b.2", 8'h12, 16'h1298);
    check("b2b.done", 32'(o_done), 32'd1);
    check("b2b.ready", 32'(o_in_ready), 32'd0);
    check("b2b.count", 32'(o_word_count), 32'd3);
    tick();
    check("b2b.after", 32'({o_done, o_busy, o_im_we}), 32'd0);

    // Unknown opcode between two valid words leaves no address gap.
    begin_session(8'h20);
    drive(OP_ADD, T0, T1, T2, 3'd1, 1'b0);
    tick();
    check_write("unk.0", 8'h20, 16'h1299);
    drive(4'd14, 3'd1, 3'd1, 3'd1, 3'd1, 1'b0);
    tick();
    check("unk.skip.we", 32'(o_im_we), 32'd0);
    check("unk.err", 32'(o_err_op), 32'd1);
    drive(OP_SW, 3'd0, 3'd0, T3, 3'd0, 1'b1);
    tick();
    idle_in();
    check_write("unk.1", 8'h21, 16'hC020);
    check("unk.count", 32'(o_word_count), 32'd2);
    check("unk.done", 32'(o_done), 32'd1);
    tick();

    // Fill to the top address; third bundle must not be accepted.
    begin_session(8'hFE);
    drive(OP_ADD, T0, T1, T2, 3'd0, 1'b0);
    tick();
    check_write("full.0", 8'hFE, 16'h1298);
    check("full.0.flag", 32'(o_full), 32'd0);
    tick();
    check_write("full.1", 8'hFF, 16'h1298);
    check("full.flag", 32'(o_full), 32'd1);
    check("full.ready", 32'(o_in_ready), 32'd0);
    check("full.done", 32'(o_done), 32'd1);
    tick();
    check("full.nowrap.we", 32'(o_im_we), 32'd0);
    check("full.count", 32'(o_word_count), 32'd2);
    check("full.idle", 32'({o_busy, o_in_ready}), 32'd0);
    tick();
    idle_in();
    check("full.still", 32'({o_im_we, o_full, o_word_count}), 32'({1'b0, 1'b1, 9'd2}));

    // Reset while the second word is on the bus.
    begin_session(8'h30);
    drive(4'd15, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
    tick();
    drive(OP_ADD, T0, T1, T2, 3'd0, 1'b0);
    tick();
    tick();
    check("rst2.pending", 32'(o_im_we), 32'd1);
    idle_in();
    i_rst = 1'b1;
    tick();
    check("rst2.we", 32'(o_im_we), 32'd0);
    check("rst2.state", 32'({o_busy, o_err_op, o_full, o_done}), 32'd0);
    check("rst2.count", 32'(o_word_count), 32'd0);
    i_rst = 1'b0;
    tick();

    // Toggling valid with start pulsed throughout the session.
    begin_session(8'h50);
    for (int i = 0; i < 6; i++) begin
      i_start     = 1'b1;
      i_base_addr = 8'h99;
      if (i % 2 == 0) drive(OP_NOP, 3'd0, 3'd0, 3'd0, 3'd0, i == 4);
      else idle_in();
      tick();
      if (i % 2 == 0) check_write($sformatf("tog.%0d", i), 8'(8'h50 + i / 2), 16'h0000);
      else check($sformatf("tog.%0d.we", i), 32'(o_im_we), 32'd0);
    end
    i_start = 1'b0;
    idle_in();
    tick();
    check("tog.idle", 32'(o_busy), 32'd0);
    check("tog.count", 32'(o_word_count), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
